// File: rtl/set_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : set_key_ctrl
// Description : Front-panel key controller. Synchronises and debounces the
//               mode/up/down buttons, sequences the set mode and issues the
//               single-cycle step pulses and the stop-clock request.
//               Auto-repeat of held up/down keys is built when the
//               AUTOREPEAT_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module set_key_ctrl #(
    parameter int DEB_CYC = 20000,
    parameter int RPT_DLY = 500000,
    parameter int RPT_PER = 100000,
    parameter int TIMEOUT = 10000000,
    parameter int CW      = 24
) (
    input  logic       clk2,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [1:0] mode,
    output logic       stp,
    output logic       increment,
    output logic       decrement
);

    typedef enum logic [1:0] {
        S_RUN  = 2'b00,
        S_HOUR = 2'b01,
        S_MIN  = 2'b10,
        S_SEC  = 2'b11
    } state_t;

    localparam logic [CW-1:0] c_deb_last = CW'(DEB_CYC - 1);
    localparam logic [CW-1:0] c_to_last  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] c_cnt_max  = '1;

    // Button order in the packed vectors: [0] mode, [1] up, [2] down.
    logic [2:0]    w_raw;
    logic [2:0]    w_press;
    logic          w_deb_up;
    logic          w_deb_dn;

    state_t        r_state;
    state_t        w_nxt_state;
    logic          r_stp;
    logic          r_inc;
    logic          r_dec;
    logic [CW-1:0] r_idle;
    logic          w_nxt_inc;
    logic          w_nxt_dec;
    logic [CW-1:0] w_nxt_idle;

    logic          w_set;
    logic          w_both;
    logic          w_timeout;
    logic          w_any_press;

    assign w_raw = {btn_down, btn_up, btn_mode};

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        logic          r_sync1;
        logic          r_sync2;
        logic          r_deb;
        logic          r_deb_q;
        logic          r_press;
        logic [CW-1:0] r_cnt;

        always_ff @(posedge clk2) begin
            if (!rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_deb   <= 1'b0;
                r_deb_q <= 1'b0;
                r_press <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_raw[gi];
                r_sync2 <= r_sync1;
                r_deb_q <= r_deb;
                // Press event is registered once more so all three buttons
                // reach the FSM with the same fixed latency.
                r_press <= r_deb & ~r_deb_q;
                if (r_sync2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_deb_last) begin
                    r_deb <= ~r_deb;
                    r_cnt <= '0;
                end else if (r_cnt != c_cnt_max) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_press[gi] = r_press;
    end

    assign w_deb_up    = g_btn[1].r_deb;
    assign w_deb_dn    = g_btn[2].r_deb;
    assign w_set       = (r_state != S_RUN);
    assign w_both      = w_deb_up & w_deb_dn;
    assign w_timeout   = w_set && (r_idle == c_to_last);
    assign w_any_press = |w_press;

`ifdef AUTOREPEAT_EN
    localparam logic [CW-1:0] c_dly_last = CW'(RPT_DLY - 1);
    localparam logic [CW-1:0] c_per_last = CW'(RPT_PER - 1);

    logic          r_rpt_act;
    logic          r_rpt_dn;
    logic          r_rpt_per;
    logic [CW-1:0] r_rpt_cnt;
    logic          w_nxt_rpt_act;
    logic          w_nxt_rpt_dn;
    logic          w_nxt_rpt_per;
    logic [CW-1:0] w_nxt_rpt_cnt;
    logic          w_rpt_held;
    logic          w_rpt_due;

    assign w_rpt_held = r_rpt_dn ? w_deb_dn : w_deb_up;
    assign w_rpt_due  = (r_rpt_cnt == (r_rpt_per ? c_per_last : c_dly_last));
`else
    logic w_unused_rpt;
    assign w_unused_rpt = ^{RPT_DLY, RPT_PER};
`endif

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_inc   = 1'b0;
        w_nxt_dec   = 1'b0;
        w_nxt_idle  = r_idle;
`ifdef AUTOREPEAT_EN
        w_nxt_rpt_act = r_rpt_act;
        w_nxt_rpt_dn  = r_rpt_dn;
        w_nxt_rpt_per = r_rpt_per;
        w_nxt_rpt_cnt = r_rpt_cnt;
`endif

        // Mode press outranks timeout and any step in the same cycle.
        if (w_press[0]) begin
            case (r_state)
                S_RUN:   w_nxt_state = S_HOUR;
                S_HOUR:  w_nxt_state = S_MIN;
                S_MIN:   w_nxt_state = S_SEC;
                S_SEC:   w_nxt_state = S_RUN;
                default: w_nxt_state = S_RUN;
            endcase
`ifdef AUTOREPEAT_EN
            w_nxt_rpt_act = 1'b0;
`endif
        end else if (w_timeout) begin
            w_nxt_state = S_RUN;
`ifdef AUTOREPEAT_EN
            w_nxt_rpt_act = 1'b0;
`endif
        end else if (w_set) begin
            if (w_both) begin
`ifdef AUTOREPEAT_EN
                w_nxt_rpt_act = 1'b0;
`endif
            end else if (w_press[1]) begin
                w_nxt_inc = 1'b1;
`ifdef AUTOREPEAT_EN
                w_nxt_rpt_act = 1'b1;
                w_nxt_rpt_dn  = 1'b0;
                w_nxt_rpt_per = 1'b0;
                w_nxt_rpt_cnt = '0;
`endif
            end else if (w_press[2]) begin
                w_nxt_dec = 1'b1;
`ifdef AUTOREPEAT_EN
                w_nxt_rpt_act = 1'b1;
                w_nxt_rpt_dn  = 1'b1;
                w_nxt_rpt_per = 1'b0;
                w_nxt_rpt_cnt = '0;
`endif
            end
`ifdef AUTOREPEAT_EN
            else if (r_rpt_act) begin
                if (!w_rpt_held) begin
                    w_nxt_rpt_act = 1'b0;
                end else if (w_rpt_due) begin
                    w_nxt_inc     = ~r_rpt_dn;
                    w_nxt_dec     = r_rpt_dn;
                    w_nxt_rpt_per = 1'b1;
                    w_nxt_rpt_cnt = '0;
                end else if (r_rpt_cnt != c_cnt_max) begin
                    w_nxt_rpt_cnt = r_rpt_cnt + 1'b1;
                end
            end
`endif
        end

        if ((w_nxt_state == S_RUN) || w_any_press || w_nxt_inc || w_nxt_dec) begin
            w_nxt_idle = '0;
        end else if (r_idle != c_cnt_max) begin
            w_nxt_idle = r_idle + 1'b1;
        end
    end

    always_ff @(posedge clk2) begin
        if (!rst) begin
            r_state <= S_RUN;
            r_stp   <= 1'b0;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
            r_idle  <= '0;
`ifdef AUTOREPEAT_EN
            r_rpt_act <= 1'b0;
            r_rpt_dn  <= 1'b0;
            r_rpt_per <= 1'b0;
            r_rpt_cnt <= '0;
`endif
        end else begin
            r_state <= w_nxt_state;
            r_stp   <= (w_nxt_state != S_RUN);
            r_inc   <= w_nxt_inc;
            r_dec   <= w_nxt_dec;
            r_idle  <= w_nxt_idle;
`ifdef AUTOREPEAT_EN
            r_rpt_act <= w_nxt_rpt_act;
            r_rpt_dn  <= w_nxt_rpt_dn;
            r_rpt_per <= w_nxt_rpt_per;
            r_rpt_cnt <= w_nxt_rpt_cnt;
`endif
        end
    end

    assign mode      = r_state;
    assign stp       = r_stp;
    assign increment = r_inc;
    assign decrement = r_dec;

endmodule
`default_nettype wire

// File: tb/tb_set_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_set_key_ctrl
// Description : Directed self-checking bench for set_key_ctrl using small
//               debounce/repeat/timeout parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_set_key_ctrl;

    logic       clk2 = 1'b0;
    logic       rst;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic [1:0] mode;
    logic       stp;
    logic       increment;
    logic       decrement;

    int n_vec     = 0;
    int n_err     = 0;
    int n_overlap = 0;
    int n_inc;
    int n_dec;
    int first_dec;
    int mode_k;
    int inc_q[$];
    int exp_q[$];
    int since;
    int ticks;
    int n_bad;

    always #5 clk2 = ~clk2;

    set_key_ctrl #(
        .DEB_CYC (4),
        .RPT_DLY (20),
        .RPT_PER (5),
        .TIMEOUT (100),
        .CW      (24)
    ) dut (
        .clk2      (clk2),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .mode      (mode),
        .stp       (stp),
        .increment (increment),
        .decrement (decrement)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    // Drive mask {down,up,mode} for ncyc edges, observe outputs for watch edges.
    task automatic hold(input logic [2:0] mask, input int ncyc, input int watch);
        logic [1:0] mode_before;
        mode_before = mode;
        n_inc = 0;
        n_dec = 0;
        first_dec = -1;
        mode_k = -1;
        inc_q.delete();
        {btn_down, btn_up, btn_mode} = mask;
        for (int k = 0; k < watch; k++) begin
            tick();
            if (increment === 1'b1) begin
                n_inc++;
                inc_q.push_back(k);
            end
            if (decrement === 1'b1) begin
                n_dec++;
                if (first_dec < 0) first_dec = k;
            end
            if (increment === 1'b1 && decrement === 1'b1) n_overlap++;
            if (mode_k < 0 && mode !== mode_before) mode_k = k;
            if (k == ncyc - 1) {btn_down, btn_up, btn_mode} = 3'b000;
        end
    endtask

    task automatic press_mode(input logic [1:0] exp_mode, input logic exp_stp);
        hold(3'b001, 6, 14);
        chk("mode_lat", mode_k, 7);
        chk("mode", mode, exp_mode);
        chk("stp", stp, exp_stp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        {btn_down, btn_up, btn_mode} = 3'b000;

        // Reset with buttons toggling
        for (int i = 0; i < 3; i++) begin
            {btn_down, btn_up, btn_mode} = (i == 1) ? 3'b010 : 3'b101;
            tick();
            chk("rst_out", {mode, stp, increment, decrement}, 0);
        end
        {btn_down, btn_up, btn_mode} = 3'b000;
        rst = 1'b1;
        n_bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if ({mode, stp, increment, decrement} !== 5'd0) n_bad++;
        end
        chk("post_rst", n_bad, 0);

        // Mode sequence and glitch rejection
        press_mode(2'b01, 1'b1);
        press_mode(2'b10, 1'b1);
        press_mode(2'b11, 1'b1);
        press_mode(2'b00, 1'b0);
        hold(3'b001, 3, 12);
        chk("glitch_k", mode_k, -1);
        chk("glitch_mode", mode, 2'b00);

        // Steps ignored in RUN
        hold(3'b010, 10, 20);
        chk("run_up_inc", n_inc, 0);
        hold(3'b100, 10, 20);
        chk("run_dn_dec", n_dec, 0);

        // Single step pulses in set-minute mode
        press_mode(2'b01, 1'b1);
        press_mode(2'b10, 1'b1);
        hold(3'b010, 10, 20);
        chk("up_n", n_inc, 1);
        chk("up_at", (inc_q.size() > 0) ? inc_q[0] : -1, 7);
        chk("up_dec", n_dec, 0);
        hold(3'b100, 10, 20);
        chk("dn_n", n_dec, 1);
        chk("dn_at", first_dec, 7);
        chk("dn_inc", n_inc, 0);

        // Held up key in set-hour mode
        press_mode(2'b11, 1'b1);
        press_mode(2'b00, 1'b0);
        press_mode(2'b01, 1'b1);
        hold(3'b010, 40, 50);
`ifdef AUTOREPEAT_EN
        exp_q = '{7, 27, 32, 37, 42};
`else
        exp_q = '{7};
`endif
        chk("rpt_n", n_inc, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk("rpt_at", (i < inc_q.size()) ? inc_q[i] : -1, exp_q[i]);

        // Up and down together, then mode and up together
        hold(3'b110, 30, 40);
        chk("both_inc", n_inc, 0);
        chk("both_dec", n_dec, 0);
        hold(3'b011, 6, 14);
        chk("mu_lat", mode_k, 7);
        chk("mu_mode", mode, 2'b10);
        chk("mu_inc", n_inc, 0);

        // Reset landing on the edge that would carry the pulse
        btn_up = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        rst = 1'b0;
        tick();
        chk("rst_mid", {mode, stp, increment, decrement}, 0);
        rst = 1'b1;
        n_bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (increment !== 1'b0) n_bad++;
        end
        btn_up = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        chk("rst_hold_inc", n_bad, 0);

        // Idle timeout from set-second mode
        press_mode(2'b01, 1'b1);
        press_mode(2'b10, 1'b1);
        press_mode(2'b11, 1'b1);
        since = 13 - mode_k;
        ticks = 0;
        while (mode === 2'b11 && ticks < 300) begin
            tick();
            ticks++;
        end
        chk("to_total", since + ticks, 100);
        chk("to_mode", mode, 2'b00);
        chk("to_stp", stp, 1'b0);

        // A press at idle count 50 restarts the timeout
        press_mode(2'b01, 1'b1);
        press_mode(2'b10, 1'b1);
        press_mode(2'b11, 1'b1);
        since = 13 - mode_k;
        while (since < 43) begin
            tick();
            since++;
        end
        hold(3'b010, 6, 14);
        chk("to_inc", n_inc, 1);
        since += 14;
        ticks = 0;
        while (mode === 2'b11 && ticks < 300) begin
            tick();
            ticks++;
        end
        chk("to_restart", since + ticks, 151);

        chk("overlap", n_overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
